// File: rtl/dff_stage.sv
// Single WIDTH-bit register stage with asynchronous active-low reset.
// One of these per pipeline position inside d_flip_flop.
module dff_stage #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/d_flip_flop.sv
// Parameterised D flip-flop / register bank / delay line: STAGES chained
// dff_stage registers sharing one clock and an asynchronous active-low reset.
module d_flip_flop #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      STAGES      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < 1) begin : g_bad_width
        $error("d_flip_flop: WIDTH must be at least 1");
    end

    if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
        $error("d_flip_flop: STAGES must be in 1..16");
    end

    // chain[0] is the input; chain[k] is the output of stage k-1.
    logic [WIDTH-1:0] chain [STAGES+1];

    assign chain[0] = d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        dff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d   (chain[k]),
            .q   (chain[k+1])
        );
    end

    assign q = chain[STAGES];

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: a 1-bit single-stage flop and an 8-bit
// three-stage delay line sharing clock and reset, checked at fixed times.
`timescale 1ns/1ps
module tb_d_flip_flop;

    logic       clk;
    logic       rst;
    logic       d1;
    logic       q1;
    logic [7:0] d2;
    logic [7:0] q2;

    int unsigned checks;
    int unsigned errors;

    d_flip_flop #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0),
        .STAGES      (1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .d   (d1),
        .q   (q1)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .STAGES      (3)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .d   (d2),
        .q   (q2)
    );

    // Rising edges at 500, 1500, 2500, ... ns.
    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic at(input time t);
        if (t > $time) #(t - $time);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        d1     = 1'b1;
        d2     = 8'h00;

        // Asynchronous reset assertion, no clock edge involved.
        at(250);   rst = 1'b0;
        at(251);   check("async_rst_q1", {7'b0, q1}, 8'h00);
                   check("async_rst_q2", q2, 8'hA5);
        at(600);   check("rst_hold_edge_q1", {7'b0, q1}, 8'h00);
                   check("rst_hold_edge_q2", q2, 8'hA5);

        // Release between edges; next edge captures.
        at(1250);  rst = 1'b1; d1 = 1'b1;
        at(1400);  check("pre_release_edge", {7'b0, q1}, 8'h00);
        at(1600);  check("first_capture", {7'b0, q1}, 8'h01);

        // Hold and capture.
        at(2600);  check("hold_2500", {7'b0, q1}, 8'h01);
        at(3600);  check("hold_3500", {7'b0, q1}, 8'h01);
        at(4450);  d1 = 1'b0;
        at(4460);  check("not_transparent", {7'b0, q1}, 8'h01);
        at(4600);  check("capture_zero", {7'b0, q1}, 8'h00);

        // Mid-cycle changes wait for the next rising edge.
        at(7550);  d1 = 1'b1;
        at(8400);  check("before_8500", {7'b0, q1}, 8'h00);
        at(8600);  check("rise_8500", {7'b0, q1}, 8'h01);
        at(11600); check("hold_11500", {7'b0, q1}, 8'h01);
        at(11650); d1 = 1'b0;
        at(12000); check("falling_edge_no_glitch", {7'b0, q1}, 8'h01);
        at(12400); check("before_12500", {7'b0, q1}, 8'h01);
        at(12600); check("fall_12500", {7'b0, q1}, 8'h00);

        // Reset mid-operation.
        at(13000); d1 = 1'b1;
        at(13600); check("q_high_pre_rst", {7'b0, q1}, 8'h01);
        at(14000); rst = 1'b0;
        at(14001); check("mid_rst_q1", {7'b0, q1}, 8'h00);
                   check("mid_rst_q2", q2, 8'hA5);
        at(15600); check("mid_rst_hold_q1", {7'b0, q1}, 8'h00);
                   check("mid_rst_hold_q2", q2, 8'hA5);
        at(16250); rst = 1'b1;
        at(16400); check("post_rst_wait_q1", {7'b0, q1}, 8'h00);
                   check("post_rst_wait_q2", q2, 8'hA5);
        at(16600); check("post_rst_capture", {7'b0, q1}, 8'h01);
        at(17000); d1 = 1'b0;
        at(17600); check("post_rst_follow", {7'b0, q1}, 8'h00);

        // Three-stage delay line: edges 16500/17500 flushed zeros in.
        at(18000); d2 = 8'h01;
        at(19000); d2 = 8'h02;
        at(19600); check("pipe_flushed", q2, 8'h00);
        at(20000); d2 = 8'h03;
        at(20400); check("pipe_before_3rd", q2, 8'h00);
        at(20600); check("pipe_out_01", q2, 8'h01);
        at(21000); d2 = 8'h00;
        at(21600); check("pipe_out_02", q2, 8'h02);
        at(22600); check("pipe_out_03", q2, 8'h03);
        at(23600); check("pipe_out_00", q2, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
